mmio_lsu: RTL
=============

# mmio_lsu

Parametrised load-store unit for the single-cycle RISC-V core, sitting between the execute stage and data memory/board I/O. It adds sub-word loads and stores with sign or zero extension, byte-enabled data RAM, a configurable number of HEX digit registers, a synchronised switch input and a valid/ready request/response handshake. Memory-mapped I/O addresses follow the board map: HEX at 0x400 + 0x10·k, LEDR 0x480, LEDG 0x490, LCD 0x4A0, SW 0x500.

## Interface
- DMEM_BYTES, 1024: data RAM size in bytes, power of two, ≤ 1024; mapped at 0x000..DMEM_BYTES-1.
- NUM_HEX, 8: number of HEX registers, 1..8.
- SW_W, 18: switch input width.
- clk_i  in  1  clock. One clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  access size and sign, RISC-V encoding.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, LSB-aligned.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  extended load data; 0 for stores.
- rsp_err_o  out  1  illegal funct3, or misaligned access when the misalign trap is compiled in.
- io_sw_i  in  SW_W  asynchronous switches.
- io_hex_o  out  NUM_HEX×32  HEX registers.
- io_ledr_o, io_ledg_o, io_lcd_o  out  32 each  output registers.

## Operation
- FSM states:
  - IDLE: req_ready_o = 1. On accept, go to RESP.
  - RESP: req_ready_o = 0, rsp_valid_o = 1. Always return to IDLE on the next clock.
- Loads (funct3):
  - 000 lb, 001 lh: sign-extended.
  - 010 lw: full word.
  - 100 lbu, 101 lhu: zero-extended.
  - Little-endian; the byte lane is selected by addr[1:0].
- Stores (funct3):
  - 000 sb, 001 sh, 010 sw.
  - The RAM or I/O register is written at the accepting edge, using byte enables only.
- Illegal funct3: any other value, including 011, 110, 111, and stores with funct3 bit 2 set.
  - rsp_err_o = 1, no write, rdata 0.
- Address decode, on addr[31:0]:
  - Data RAM range → RAM.
  - I/O word addresses (low nibble 0..3 within each register) → register.
  - SW (0x500) reads as zero-extended synchronised switches. Stores to SW are ignored with no error.
  - HEX k ≥ NUM_HEX and unmapped addresses: read 0, writes ignored, no error.
- Switches pass through a 2-flop synchroniser. The reset value is 0.
- Output registers reset to 0. Data RAM is not reset.

## Timing
- Every request has a latency of exactly 1 cycle: accept at edge N, rsp_valid_o high for cycle N+1, rsp fields stable only during that cycle.
- Maximum throughput is one request per 2 cycles.
- Stored values appear on I/O outputs one cycle after the accepting edge.
- A load of an address stored by the immediately preceding request returns the new data.
- Switch changes become visible to loads 2–3 cycles later.
- Reset asserted mid-operation:
  - FSM returns to IDLE and any pending response is dropped.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - req_ready_o = 1 while in reset.
- When req_valid_i is low in IDLE, nothing changes.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] ≠ 0, produce rsp_err_o = 1.
  - No write occurs and rdata is 0.
- Undefined:
  - Misaligned addresses are forced to natural alignment by clearing the low address bits.
  - rsp_err_o reports only illegal funct3.

## Structure
- Package lsu_pkg holds:
  - The I/O address constants.
  - The funct3 enum.
  - The FSM state enum.
  - The byte-enable/extension helper functions.
- Sub-module dmem_sp: synchronous single-port byte-enabled RAM, DMEM_BYTES/4 words, read data registered.
- The top level holds the FSM, decode, I/O registers, synchroniser and response mux.

## Test plan
- Reset, then sw 0x000 ← 0x8899AABB, then lw 0x000 → rdata 0x8899AABB, err 0. The response arrives exactly 1 cycle after accept, and req_ready_o is low during the response.
- lb 0x003 → 0xFFFFFF88. lbu 0x003 → 0x00000088. lh 0x002 → 0xFFFF8899. sb 0x001 ← 0x11, then lw 0x000 → 0x8899_11BB.
- sw 0x400 ← 0x7F and sw 0x480 ← 0x3FFFF: io_hex_o[0] = 0x7F and io_ledr_o = 0x3FFFF one cycle after each accept. Assert rst_ni, then all outputs read 0.
- io_sw_i = 0x2A5A5, then lw 0x500: reads 0 within 1 cycle of the change, then 0x0002A5A5 from the third cycle on. sw 0x500 is ignored.
- lw 0x002:
  - With LSU_MISALIGN_TRAP_EN: err 1, rdata 0.
  - Without: returns the word at 0x000, err 0.
  - funct3 011 gives err 1 in both builds.
- Drop rst_ni during RESP: rsp_valid_o goes low immediately, and the FSM is in IDLE with ready high after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the mmio_lsu load-store unit.
// Contents: board I/O address map, RISC-V load/store funct3 encodings,
// FSM state type, and helpers for byte enables, store lane placement,
// load extension and byte-enable merging into I/O registers.
package lsu_pkg;

  localparam logic [31:0] ADDR_HEX  = 32'h0000_0400;  // HEX k at ADDR_HEX + 0x10*k
  localparam logic [31:0] ADDR_LEDR = 32'h0000_0480;
  localparam logic [31:0] ADDR_LEDG = 32'h0000_0490;
  localparam logic [31:0] ADDR_LCD  = 32'h0000_04A0;
  localparam logic [31:0] ADDR_SW   = 32'h0000_0500;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  // Loads accept all five encodings; stores only the signed-size ones.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (funct3_e'(f3))
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (funct3_e'(f3))
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Natural alignment: clear the low address bits for the access size.
  function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] addr);
    case (funct3_e'(f3))
      F3_H, F3_HU: return {addr[31:1], 1'b0};
      F3_W:        return {addr[31:2], 2'b00};
      default:     return addr;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    case (funct3_e'(f3))
      F3_B, F3_BU: return 4'b0001 << lane;
      F3_H, F3_HU: return 4'b0011 << lane;
      F3_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [1:0] lane);
    return wdata << {lane, 3'b000};
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (funct3_e'(f3))
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_W:    return word;
      F3_BU:   return {24'h0, sh[7:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] data,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_lsu_if.sv
// mmio_lsu_if: request/response handshake between the execute stage
// (master) and the load-store unit (slave).
//   req_valid_i/req_ready_o  request handshake
//   req_we_i, req_funct3_i, req_addr_i, req_wdata_i  request payload
//   rsp_valid_o, rsp_rdata_o, rsp_err_o  one-cycle response
interface mmio_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_sp.sv
// dmem_sp: synchronous single-port data RAM, 32-bit words, byte enables,
// registered read data (read-before-write). Contents are not reset.
//   clk, addr (word index), we, be[3:0], wdata -> rdata (next cycle)
module dmem_sp #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mmio_lsu.sv
// mmio_lsu: load-store unit with byte-enabled data RAM and board MMIO.
// Ports: clk_i, rst_ni (async active-low); lsu (mmio_lsu_if.slave) for the
// request/response handshake; io_sw_i switches (2-flop synchronised);
// io_hex_o[NUM_HEX], io_ledr_o, io_ledg_o, io_lcd_o output registers.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned lh/lhu/sh/lw/sw
// report rsp_err_o; otherwise the address is forced to natural alignment.
module mmio_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned SW_W       = 18
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  mmio_lsu_if.slave                 lsu,
  input  logic [SW_W-1:0]           io_sw_i,
  output logic [NUM_HEX-1:0][31:0]  io_hex_o,
  output logic [31:0]               io_ledr_o,
  output logic [31:0]               io_ledg_o,
  output logic [31:0]               io_lcd_o
);

  localparam int unsigned WORDS = DMEM_BYTES / 4;
  localparam int unsigned AW    = $clog2(WORDS);

  state_e          state;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic            legal, err, accept, do_write;
  logic            in_ram, reg_word, sel_hex, sel_ledr, sel_ledg, sel_lcd, sel_sw;
  logic [31:0]     eff_addr, wdata_al, io_word, ram_rdata, io_rdata_q;
  logic [1:0]      lane, lane_q;
  logic [2:0]      hex_idx, f3_q;
  logic [3:0]      be;
  logic            ram_q, load_ok_q;

  always_comb begin
    legal = funct3_legal(lsu.req_we_i, lsu.req_funct3_i);
`ifdef LSU_MISALIGN_TRAP_EN
    eff_addr = lsu.req_addr_i;
    err      = !legal || misaligned(lsu.req_funct3_i, lsu.req_addr_i[1:0]);
`else
    eff_addr = align_addr(lsu.req_funct3_i, lsu.req_addr_i);
    err      = !legal;
`endif
  end

  assign accept   = (state == S_IDLE) && lsu.req_valid_i;
  assign do_write = accept && lsu.req_we_i && !err;
  assign lane     = eff_addr[1:0];
  assign be       = byte_en(lsu.req_funct3_i, lane);
  assign wdata_al = store_align(lsu.req_wdata_i, lane);

  // Each I/O register occupies the first word of its 16-byte slot.
  assign in_ram   = eff_addr < 32'(DMEM_BYTES);
  assign reg_word = eff_addr[3:2] == 2'b00;
  assign hex_idx  = eff_addr[6:4];
  assign sel_hex  = reg_word && (eff_addr[31:7] == ADDR_HEX[31:7]) && (32'(hex_idx) < NUM_HEX);
  assign sel_ledr = reg_word && (eff_addr[31:4] == ADDR_LEDR[31:4]);
  assign sel_ledg = reg_word && (eff_addr[31:4] == ADDR_LEDG[31:4]);
  assign sel_lcd  = reg_word && (eff_addr[31:4] == ADDR_LCD[31:4]);
  assign sel_sw   = reg_word && (eff_addr[31:4] == ADDR_SW[31:4]);

  always_comb begin
    io_word = '0;
    if (sel_hex)  io_word = io_hex_o[hex_idx];
    if (sel_ledr) io_word = io_ledr_o;
    if (sel_ledg) io_word = io_ledg_o;
    if (sel_lcd)  io_word = io_lcd_o;
    if (sel_sw)   io_word = 32'(sw_sync);
  end

  dmem_sp #(.WORDS(WORDS), .AW(AW)) u_dmem (
    .clk   (clk_i),
    .addr  (eff_addr[AW+1:2]),
    .we    (do_write && in_ram),
    .be    (be),
    .wdata (wdata_al),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      io_hex_o  <= '0;
      io_ledr_o <= '0;
      io_ledg_o <= '0;
      io_lcd_o  <= '0;
    end else begin
      sw_meta <= io_sw_i;
      sw_sync <= sw_meta;
      if (do_write) begin
        for (int unsigned k = 0; k < NUM_HEX; k++) begin
          if (sel_hex && (32'(hex_idx) == k)) io_hex_o[k] <= merge_be(io_hex_o[k], wdata_al, be);
        end
        if (sel_ledr) io_ledr_o <= merge_be(io_ledr_o, wdata_al, be);
        if (sel_ledg) io_ledg_o <= merge_be(io_ledg_o, wdata_al, be);
        if (sel_lcd)  io_lcd_o  <= merge_be(io_lcd_o, wdata_al, be);
      end
    end
  end

  // The raw word (RAM or I/O) is captured at accept; extension to the
  // requested size happens in the response cycle from the captured fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= S_IDLE;
      lsu.req_ready_o <= 1'b1;
      lsu.rsp_valid_o <= 1'b0;
      lsu.rsp_err_o   <= 1'b0;
      f3_q            <= '0;
      lane_q          <= '0;
      ram_q           <= 1'b0;
      load_ok_q       <= 1'b0;
      io_rdata_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu.req_valid_i) begin
            state           <= S_RESP;
            lsu.req_ready_o <= 1'b0;
            lsu.rsp_valid_o <= 1'b1;
            lsu.rsp_err_o   <= err;
            f3_q            <= lsu.req_funct3_i;
            lane_q          <= lane;
            ram_q           <= in_ram;
            load_ok_q       <= !lsu.req_we_i && !err;
            io_rdata_q      <= io_word;
          end
        end
        S_RESP: begin
          state           <= S_IDLE;
          lsu.req_ready_o <= 1'b1;
          lsu.rsp_valid_o <= 1'b0;
          lsu.rsp_err_o   <= 1'b0;
          load_ok_q       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu.rsp_rdata_o = (lsu.rsp_valid_o && load_ok_q)
                         ? load_ext(ram_q ? ram_rdata : io_rdata_q, f3_q, lane_q) : '0;

endmodule
